// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
//
// Purpose:
//   Refills one cache block after a lookup miss. When a miss is seen in IDLE
//   the block base address is latched and the FSM moves to FILL. In FILL it:
//     - issues one memory read per cycle until every word of the block has
//       been requested;
//     - writes each returned word into the data array in the same cycle it
//       arrives;
//     - writes the tag on the final word and then returns to IDLE.
//   Memory returns words in request order, so the word offset of each
//   returned word is recomputed from a receive counter.
//
// Configuration:
//   CACHE_FILL_CRITICAL_WORD_EN
//     Defined:   the fill starts at the missing word and wraps around the
//                block (critical word first). This applies to both the read
//                order and the fill_word order.
//     Undefined: the fill always runs from word 0 to word 7, and the latched
//                start offset is not used.
//
// Parameters:
//   WORDS_PER_BLOCK  16-bit words per block (only 8 is supported)
//   ADDR_W           byte-address width
//
// Ports:
//   clk                input   single clock, rising edge
//   rst_n              input   asynchronous active-low reset
//   miss_detected      input   cache lookup missed this cycle
//   miss_address       input   byte address of the missing access
//   memory_data_valid  input   memory_data carries one returned word
//   memory_data        input   word returned by main memory
//   fsm_busy           output  fill in progress, pipeline stalled
//   memory_read        output  memory_address is a valid read request
//   memory_address     output  read request byte address
//   write_data_array   output  write fill_data at fill_word
//   write_tag_array    output  write tag / set valid, block complete
//   fill_word          output  word offset being written
//   fill_data          output  data being written (equals memory_data)
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              fsm_busy,
    output logic              memory_read,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [2:0]        fill_word,
    output logic [15:0]       fill_data
);

    localparam logic [3:0] NUM_WORDS = 4'(WORDS_PER_BLOCK);
    localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        start_q, start_d;
    logic [3:0]        issue_cnt_q, issue_cnt_d;
    logic [3:0]        recv_cnt_q, recv_cnt_d;
    logic [2:0]        issue_off;
    logic [2:0]        recv_off;

    // Word offsets for the next request and the next returned word. In
    // critical-word-first mode both counters are rotated by the start word;
    // the 3-bit sum wraps inside the block, so the base is never crossed.
    always_comb begin
`ifdef CACHE_FILL_CRITICAL_WORD_EN
        issue_off = start_q + issue_cnt_q[2:0];
        recv_off  = start_q + recv_cnt_q[2:0];
`else
        issue_off = issue_cnt_q[2:0];
        recv_off  = recv_cnt_q[2:0];
`endif
    end

    // Next-state and output decode. The write strobes follow
    // memory_data_valid in the same cycle, but only in FILL. As a result,
    // stray data in IDLE, and anything that arrives during reset, never
    // reaches the arrays.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        start_d          = start_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;

        fsm_busy         = 1'b0;
        memory_read      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_word        = 3'd0;
        fill_data        = 16'd0;

        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    base_d      = {miss_address[ADDR_W-1:4], 4'b0000};
                    start_d     = miss_address[3:1];
                    issue_cnt_d = 4'd0;
                    recv_cnt_d  = 4'd0;
                    state_d     = FILL;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;

                if (issue_cnt_q < NUM_WORDS) begin
                    memory_read    = 1'b1;
                    memory_address = base_q + {{(ADDR_W-4){1'b0}}, issue_off, 1'b0};
                    issue_cnt_d    = issue_cnt_q + 4'd1;
                end

                // Returned words may overlap with outstanding issues. The
                // final word closes the block and also writes the tag.
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_word        = recv_off;
                    fill_data        = memory_data;
                    recv_cnt_d       = recv_cnt_q + 4'd1;
                    if (recv_cnt_q == LAST_WORD) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset clears everything, including an
    // in-flight fill, so an aborted fill can never reach the tag write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            start_q     <= 3'd0;
            issue_cnt_q <= 4'd0;
            recv_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            start_q     <= start_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_fsm
//
// Self-checking bench for cache_fill_fsm.
//
// Memory model:
//   - Each expected read is queued with a return cycle.
//   - Return cycles are strictly increasing, so words come back in request
//     order, one per cycle.
//   - The data for each word is random.
//
// Expected values, computed from the block rules:
//   - Read addresses:  block base + 2 * ((start + i) mod 8).
//   - fill_word:       word index of the address whose data is being
//                      returned.
//   - Tag write:       on the eighth returned word.
//
// Build with CACHE_FILL_CRITICAL_WORD_EN to match a DUT built the same way.
// ---------------------------------------------------------------------------
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'd0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'd0;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;

    int checks = 0;
    int errors = 0;

`ifdef CACHE_FILL_CRITICAL_WORD_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    typedef struct {
        int          rel;
        logic [15:0] addr;
        logic [15:0] data;
    } beat_t;

    always #5 clk = ~clk;

    cache_fill_fsm #(
        .WORDS_PER_BLOCK(8),
        .ADDR_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .miss_detected(miss_detected),
        .miss_address(miss_address),
        .memory_data_valid(memory_data_valid),
        .memory_data(memory_data),
        .fsm_busy(fsm_busy),
        .memory_read(memory_read),
        .memory_address(memory_address),
        .write_data_array(write_data_array),
        .write_tag_array(write_tag_array),
        .fill_word(fill_word),
        .fill_data(fill_data)
    );

    // Reference address of the i-th read of the fill triggered by a miss.
    function automatic logic [15:0] model_read_addr(input logic [15:0] miss, input int i);
        int base;
        int start;
        base  = int'(miss) & 32'hFFF0;
        start = CRIT ? int'(miss[3:1]) : 0;
        return 16'(base + 2 * ((start + i) % 8));
    endfunction

    // Runs one fill starting from IDLE at posedge+1 and returns at posedge+1.
    // lat = 0 picks a random latency per read. With hold set, the miss stays
    // asserted (at hold_addr) for the whole fill. The task returns early once
    // stop_after words have been received.
    task automatic run_fill(input logic [15:0] addr, input int lat, input bit hold,
                            input logic [15:0] hold_addr, input int stop_after,
                            output int busy_cycles);
        beat_t       pend[$];
        beat_t       b;
        int          issued;
        int          recvd;
        int          cyc;
        int          last_rel;
        bit          v;
        bit          exp_rd;
        logic [15:0] exp_addr;
        logic [2:0]  exp_word;
        issued      = 0;
        recvd       = 0;
        cyc         = 0;
        last_rel    = -1;
        busy_cycles = 0;

        miss_detected     = 1'b1;
        miss_address      = addr;
        memory_data_valid = 1'b1;
        memory_data       = 16'($urandom);
        @(negedge clk);
        checks++;
        if ({fsm_busy, memory_read, write_data_array, write_tag_array} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_before_fill(%h): got busy/rd/wd/wt=%b, expected 0000",
                     addr, {fsm_busy, memory_read, write_data_array, write_tag_array});
        end
        @(posedge clk);
        #1;

        while (recvd < stop_after) begin
            if (cyc > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL fill_timeout(%h): got %0d words, expected %0d", addr, recvd, stop_after);
                break;
            end
            if (hold) begin
                miss_detected = 1'b1;
                miss_address  = hold_addr;
            end else begin
                miss_detected = 1'($urandom_range(0, 1));
                miss_address  = 16'($urandom);
            end
            v = (pend.size() > 0) && (pend[0].rel <= cyc);
            memory_data_valid = v;
            memory_data       = v ? pend[0].data : 16'($urandom);

            @(negedge clk);
            busy_cycles++;

            checks++;
            if (fsm_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL busy(%h,c%0d): got %b, expected 1", addr, cyc, fsm_busy);
            end

            exp_rd   = (issued < 8);
            exp_addr = exp_rd ? model_read_addr(addr, issued) : 16'd0;
            checks++;
            if (memory_read !== exp_rd) begin
                errors++;
                $display("[TB] FAIL memory_read(%h,c%0d): got %b, expected %b", addr, cyc, memory_read, exp_rd);
            end
            checks++;
            if (memory_address !== exp_addr) begin
                errors++;
                $display("[TB] FAIL memory_address(%h,c%0d): got %h, expected %h", addr, cyc, memory_address, exp_addr);
            end
            if (exp_rd) begin
                b.rel  = (lat > 0) ? cyc + lat : cyc + $urandom_range(1, 6);
                if (b.rel <= last_rel) b.rel = last_rel + 1;
                last_rel = b.rel;
                b.addr = exp_addr;
                b.data = 16'($urandom);
                pend.push_back(b);
                issued++;
            end

            if (v) begin
                b = pend.pop_front();
                exp_word = b.addr[3:1];
                checks++;
                if (write_data_array !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL write_data(%h,w%0d): got %b, expected 1", addr, recvd, write_data_array);
                end
                checks++;
                if (fill_word !== exp_word) begin
                    errors++;
                    $display("[TB] FAIL fill_word(%h,w%0d): got %0d, expected %0d", addr, recvd, fill_word, exp_word);
                end
                checks++;
                if (fill_data !== b.data) begin
                    errors++;
                    $display("[TB] FAIL fill_data(%h,w%0d): got %h, expected %h", addr, recvd, fill_data, b.data);
                end
                checks++;
                if (write_tag_array !== (recvd == 7)) begin
                    errors++;
                    $display("[TB] FAIL write_tag(%h,w%0d): got %b, expected %b", addr, recvd, write_tag_array, (recvd == 7));
                end
                recvd++;
            end else begin
                checks++;
                if ({write_data_array, write_tag_array} !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL no_write(%h,c%0d): got wd/wt=%b, expected 00", addr, cyc, {write_data_array, write_tag_array});
                end
            end

            @(posedge clk);
            #1;
            cyc++;
        end

        memory_data_valid = 1'b0;
        if (!hold) miss_detected = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        rst_n             = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = 16'h1236;
        memory_data_valid = 1'b1;
        memory_data       = 16'hA5A5;
        #1;
        checks++;
        if ({fsm_busy, memory_read, memory_address, write_data_array, write_tag_array, fill_word, fill_data} !== 39'd0) begin
            errors++;
            $display("[TB] FAIL reset_async: got outputs %h, expected 0",
                     {fsm_busy, memory_read, memory_address, write_data_array, write_tag_array, fill_word, fill_data});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({fsm_busy, memory_read, memory_address, write_data_array, write_tag_array, fill_word, fill_data} !== 39'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold(%0d): got outputs %h, expected 0", i,
                         {fsm_busy, memory_read, memory_address, write_data_array, write_tag_array, fill_word, fill_data});
            end
        end
        @(posedge clk);
        #1;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        rst_n             = 1'b1;
    endtask

    task automatic test_directed_fill();
        int bc;
        run_fill(16'h1236, 4, 1'b0, 16'h0000, 8, bc);
        checks++;
        if (bc !== 12) begin
            errors++;
            $display("[TB] FAIL busy_cycles_1236: got %0d, expected 12", bc);
        end
    endtask

    task automatic test_block_wrap();
        int bc;
        run_fill(16'hFFFE, 0, 1'b0, 16'h0000, 8, bc);
        run_fill(16'h000E, 0, 1'b0, 16'h0000, 8, bc);
    endtask

    task automatic test_back_to_back();
        int          bc;
        logic [15:0] a1;
        logic [15:0] a2;
        a1 = 16'($urandom);
        a2 = 16'($urandom);
        run_fill(a1, 3, 1'b1, a2, 8, bc);
        run_fill(a2, 0, 1'b0, 16'h0000, 8, bc);
    endtask

    task automatic test_reset_mid_fill();
        int bc;
        run_fill(16'h2468, 4, 1'b0, 16'h0000, 3, bc);
        miss_detected     = 1'b0;
        memory_data_valid = 1'b1;
        memory_data       = 16'h5A5A;
        #1;
        checks++;
        if (write_data_array !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_abort_write: got %b, expected 1", write_data_array);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fsm_busy, memory_read, memory_address, write_data_array, write_tag_array, fill_word, fill_data} !== 39'd0) begin
            errors++;
            $display("[TB] FAIL abort_async: got outputs %h, expected 0",
                     {fsm_busy, memory_read, memory_address, write_data_array, write_tag_array, fill_word, fill_data});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({fsm_busy, memory_read, memory_address, write_data_array, write_tag_array, fill_word, fill_data} !== 39'd0) begin
            errors++;
            $display("[TB] FAIL abort_hold: got outputs %h, expected 0",
                     {fsm_busy, memory_read, memory_address, write_data_array, write_tag_array, fill_word, fill_data});
        end
        memory_data_valid = 1'b0;
        rst_n             = 1'b1;
        run_fill(16'h9ABC, 0, 1'b0, 16'h0000, 8, bc);
    endtask

    task automatic test_stray_valid();
        for (int i = 0; i < 4; i++) begin
            miss_detected     = 1'b0;
            memory_data_valid = 1'b1;
            memory_data       = 16'hBEEF;
            @(negedge clk);
            checks++;
            if ({fsm_busy, memory_read, memory_address, write_data_array, write_tag_array, fill_word, fill_data} !== 39'd0) begin
                errors++;
                $display("[TB] FAIL stray_valid(%0d): got outputs %h, expected 0", i,
                         {fsm_busy, memory_read, memory_address, write_data_array, write_tag_array, fill_word, fill_data});
            end
            @(posedge clk);
            #1;
        end
        memory_data_valid = 1'b0;
    endtask

    task automatic test_random_fills();
        int bc;
        int gap;
        for (int n = 0; n < 20; n++) begin
            run_fill(16'($urandom), 0, 1'b0, 16'h0000, 8, bc);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                memory_data_valid = 1'($urandom_range(0, 1));
                memory_data       = 16'($urandom);
                @(negedge clk);
                checks++;
                if ({fsm_busy, write_data_array, write_tag_array} !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL idle_gap(%0d,%0d): got busy/wd/wt=%b, expected 000", n, g,
                             {fsm_busy, write_data_array, write_tag_array});
                end
                @(posedge clk);
                #1;
            end
            memory_data_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed_fill();
        test_block_wrap();
        test_back_to_back();
        test_reset_mid_fill();
        test_stray_valid();
        test_random_fills();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
